// File: rtl/adc_frame_packer.sv
// -----------------------------------------------------------------------------
// adc_frame_packer
// Transmit-side source for the lane ADC interface. Collects a serial stream of
// per-channel IQ samples (channel 0 flagged by s_sof) into one packed frame
// {chN-1_Q, chN-1_I, ..., ch0_Q, ch0_I} and pulses adc_valid for one cycle per
// completed frame. A start-of-frame that arrives before the frame is complete
// counts as a framing error; the partial frame is dropped and a new frame
// starts with that sample.
//
// Optional build macro: ADC_OFFSET_BINARY_EN
//   defined   - s_i / s_q are offset-binary; the MSB is inverted on capture
//   undefined - samples are stored bit-exact
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   en              in   packer enable, gates s_ready
//   s_i, s_q        in   I / Q sample of the current channel
//   s_sof           in   marks channel 0 of a frame
//   s_valid         in   sample present
//   s_ready         out  sample accepted this cycle (combinational)
//   adc_data_packed out  last completed frame
//   adc_valid       out  one-cycle pulse, adc_data_packed is new
//   frame_cnt       out  completed frames, wraps
//   sync_err_cnt    out  framing errors, saturates at 255
//   busy            out  partial frame held
// -----------------------------------------------------------------------------
module adc_frame_packer #(
    parameter int unsigned NUM_CH    = 24,
    parameter int unsigned IQ_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [IQ_WIDTH-1:0]          s_i,
    input  logic [IQ_WIDTH-1:0]          s_q,
    input  logic                         s_sof,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [NUM_CH*2*IQ_WIDTH-1:0] adc_data_packed,
    output logic                         adc_valid,
    output logic [CNT_WIDTH-1:0]         frame_cnt,
    output logic [7:0]                   sync_err_cnt,
    output logic                         busy
);

    localparam int unsigned PAIR_W  = 2 * IQ_WIDTH;
    localparam int unsigned FRAME_W = NUM_CH * PAIR_W;
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LAST_CH = NUM_CH - 1;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_FILL     = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_ch_cnt;
    logic [FRAME_W-1:0]  r_buf;
    logic [FRAME_W-1:0]  r_data;
    logic                r_valid;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic [7:0]          r_err_cnt;

    logic                w_accept;
    logic                w_last_ch;
    logic [IQ_WIDTH-1:0] w_i;
    logic [IQ_WIDTH-1:0] w_q;
    logic [PAIR_W-1:0]   w_sample;
    logic [FRAME_W-1:0]  w_frame;

    // FSM decode outputs
    logic                w_start;     // sample to slot 0, ch_cnt <= 1
    logic                w_fill;      // sample to slot ch_cnt, ch_cnt++
    logic                w_complete;  // publish frame
    logic                w_sync_err;  // premature start-of-frame

    // en is ignored while reset is asserted
    assign s_ready  = en & ~rst;
    assign w_accept = s_valid & s_ready;
    assign w_last_ch = (r_ch_cnt == CH_W'(LAST_CH));

    // Sample capture, optional offset-binary to two's complement
`ifdef ADC_OFFSET_BINARY_EN
    assign w_i = {~s_i[IQ_WIDTH-1], s_i[IQ_WIDTH-2:0]};
    assign w_q = {~s_q[IQ_WIDTH-1], s_q[IQ_WIDTH-2:0]};
`else
    assign w_i = s_i;
    assign w_q = s_q;
`endif
    assign w_sample = {w_q, w_i};

    // Completed frame: held slots plus the final sample in the last slot
    always_comb begin
        w_frame = r_buf;
        w_frame[LAST_CH*PAIR_W +: PAIR_W] = w_sample;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_SOF: begin
                if (w_accept && s_sof && (NUM_CH > 1)) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept && !s_sof && w_last_ch) begin
                    w_state_nxt = ST_WAIT_SOF;
                end
            end
            default: w_state_nxt = ST_WAIT_SOF;
        endcase
    end

    // Output decode
    always_comb begin
        w_start    = 1'b0;
        w_fill     = 1'b0;
        w_complete = 1'b0;
        w_sync_err = 1'b0;
        case (r_state)
            ST_WAIT_SOF: begin
                if (w_accept && s_sof) begin
                    // a single-channel frame completes on its SOF sample
                    if (NUM_CH == 1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_start = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    if (s_sof) begin
                        w_sync_err = 1'b1;
                        w_start    = 1'b1;
                    end else if (w_last_ch) begin
                        w_complete = 1'b1;
                    end else begin
                        w_fill = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Assembly buffer, output frame and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch_cnt    <= '0;
            r_buf       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_buf[0 +: PAIR_W] <= w_sample;
                r_ch_cnt           <= CH_W'(1);
            end
            if (w_fill) begin
                r_buf[32'(r_ch_cnt) * PAIR_W +: PAIR_W] <= w_sample;
                r_ch_cnt <= r_ch_cnt + CH_W'(1);
            end
            if (w_complete) begin
                r_data      <= w_frame;
                r_valid     <= 1'b1;
                r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                r_ch_cnt    <= '0;
            end
            if (w_sync_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign adc_data_packed = r_data;
    assign adc_valid       = r_valid;
    assign frame_cnt       = r_frame_cnt;
    assign sync_err_cnt    = r_err_cnt;
    assign busy            = (r_state == ST_FILL);

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Transmit-side source for the lane ADC interface.
- Accepts a serial per-channel IQ sample stream, one channel per handshake, in channel order 0..NUM_CH-1, delimited by a start-of-frame flag.
- Assembles each frame into the packed bus {chN-1_Q, chN-1_I, ..., ch0_Q, ch0_I} and issues a single-cycle adc_valid per completed frame.
- Detects and recovers from framing errors and keeps frame and error statistics.

Parameters:
- NUM_CH, 24: channels per frame (per lane).
- IQ_WIDTH, 16: bits per I or Q sample.
- CNT_WIDTH, 16: width of the completed-frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  packer enable; gates s_ready
- s_i  in  IQ_WIDTH  I sample of the current channel
- s_q  in  IQ_WIDTH  Q sample of the current channel
- s_sof  in  1  marks channel 0 of a frame
- s_valid  in  1  sample present
- s_ready  out  1  packer accepts a sample this cycle
- adc_data_packed  out  NUM_CH*2*IQ_WIDTH  assembled frame; channel k I at [2k*IQ_WIDTH +: IQ_WIDTH], Q at [(2k+1)*IQ_WIDTH +: IQ_WIDTH]
- adc_valid  out  1  one-cycle pulse, frame on adc_data_packed is new
- frame_cnt  out  CNT_WIDTH  completed frames, wraps
- sync_err_cnt  out  8  framing errors, saturates at 255
- busy  out  1  partial frame held (state FILL)

Behaviour:
- Reset (rst high, async) clears:
  - adc_data_packed, adc_valid, frame_cnt, sync_err_cnt, busy and the assembly buffer to 0;
  - the channel counter to 0;
  - the state to WAIT_SOF.
- s_ready = en, combinational. Reset deasserts it, because en is ignored while rst is high (s_ready = en & ~rst).
- Accept is s_valid & s_ready. Nothing changes without an accept, except that adc_valid clears.
- State WAIT_SOF:
  - accept with s_sof=1: write the sample to assembly slot 0, ch_cnt<=1, go to FILL.
  - accept with s_sof=0: drop the sample, no counter change.
- State FILL:
  - accept with s_sof=0 and ch_cnt<NUM_CH-1: write slot ch_cnt, ch_cnt++.
  - accept with s_sof=0 and ch_cnt==NUM_CH-1 (frame completes):
    - load adc_data_packed with slots 0..NUM_CH-2 plus this sample in slot NUM_CH-1;
    - adc_valid<=1 for the next cycle only;
    - frame_cnt++ (wraps);
    - ch_cnt<=0, go to WAIT_SOF.
  - accept with s_sof=1 (premature SOF):
    - sync_err_cnt++ (saturating);
    - discard the partial frame;
    - write this sample to slot 0, ch_cnt<=1, stay in FILL.
- Latency: adc_valid is high in exactly the cycle after the edge that accepted channel NUM_CH-1.
- adc_data_packed is stable from that cycle until the next completed frame.
- Back-to-back frames are supported with no gap. adc_valid is then high one cycle every NUM_CH accepts.
- en low mid-frame stalls intake. The partial frame and ch_cnt are retained, and filling resumes when en returns.
- busy = (state==FILL).
- With NUM_CH==1, an SOF accept completes the frame directly: no FILL, no error path.
- Reset mid-frame discards the partial frame. The previous adc_data_packed is also cleared to 0.
- Samples are passed bit-exact, with no arithmetic, unless the optional feature is enabled.

Optional Feature:
- Macro: ADC_OFFSET_BINARY_EN.
- Defined: s_i and s_q are offset-binary. The MSB of each is inverted on capture to give two's complement (0x0000 -> 0x8000, 0x8000 -> 0x0000, 0xFFFF -> 0x7FFF).
- Undefined: samples are stored unmodified. No conversion logic is present.

Test Plan:
- Reset, then en=1. Send 24 accepts, ch k: s_i=k, s_q=0x100+k, SOF on k=0 -> adc_valid one cycle after the 24th accept; slot 5 I=0x0005, Q=0x0105; frame_cnt=1; busy=0.
- Three back-to-back frames with continuous s_valid -> adc_valid pulses 24 cycles apart; frame_cnt=3; sync_err_cnt=0.
- 10 samples, then SOF with s_i=0xAAAA, then 23 more -> sync_err_cnt=1; one adc_valid only; slot 0 I=0xAAAA.
- 5 samples with s_sof=0 after reset -> all dropped; busy=0; no adc_valid. Next SOF starts the frame normally.
- en=0 for 7 cycles after ch 11 -> s_ready=0, busy=1. Frame completes correctly after en=1, adc_valid 1 cycle after ch 23.
- rst pulse after ch 15 -> all outputs 0 immediately. Next full frame produces a correct frame with frame_cnt=1. With ADC_OFFSET_BINARY_EN, s_i=0x8000 reads 0x0000.
